// File: rtl/apb_reg_slave_pkg.sv
// rtl/apb_reg_slave_pkg.sv - shared types and constants for the APB register slave
//
// Package apb_slave_pkg
//   state_t          : transfer FSM states (IDLE, ACCESS)
//   APB_DATA_W       : APB data/address width
//   APB_STRB_W       : number of byte strobes
//   DEFAULT_ID_VALUE : default constant returned by register 0
// No ports.
package apb_slave_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int APB_DATA_W = 32;
   localparam int APB_STRB_W = APB_DATA_W / 8;

   localparam logic [APB_DATA_W-1:0] DEFAULT_ID_VALUE = 32'hA5B0_0001;

endpackage

// File: rtl/apb_reg_slave_if.sv
// rtl/apb_reg_slave_if.sv - APB bus bundle between the bridge and the register slave
//
// Interface apb_reg_slave_if
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB : driven by the bridge (master)
//   PRDATA, PREADY, PSLVERR                     : driven by the slave
// Modports: master (bridge side), slave (register slave side).
interface apb_reg_slave_if;
   import apb_slave_pkg::*;

   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [APB_DATA_W-1:0] PADDR;
   logic [APB_DATA_W-1:0] PWDATA;
   logic [APB_STRB_W-1:0] PSTRB;
   logic [APB_DATA_W-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_wait_counter.sv
// rtl/apb_wait_counter.sv - access-phase wait-state counter
//
// Ports
//   HCLK  in  clock, posedge
//   HRSTn in  synchronous active-low reset (count cleared)
//   load  in  reload the count with WAIT_CYCLES (setup phase)
//   dec   in  decrement request; ignored once the count is zero
//   zero  out count has reached zero
module apb_wait_counter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic HCLK,
   input  logic HRSTn,
   input  logic load,
   input  logic dec,
   output logic zero
);

   // At least one bit so WAIT_CYCLES=0 still yields a legal vector.
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge HCLK) begin
      if (!HRSTn) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= CNT_W'(WAIT_CYCLES);
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB completer with a NUM_REGS x 32-bit register bank
//
// Register 0 is a read-only ID; registers 1..NUM_REGS-1 are read/write with
// byte strobes. The access phase is stretched by WAIT_CYCLES wait states.
// Build option APB_SLVERR_EN: drive PSLVERR on out-of-range accesses and
// writes to the ID register; otherwise PSLVERR is tied low.
//
// Ports
//   HCLK  in  clock, posedge
//   HRSTn in  synchronous active-low reset
//   bus   apb_reg_slave_if.slave : PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB in,
//                                  PRDATA/PREADY/PSLVERR out
module apb_reg_slave
   import apb_slave_pkg::*;
#(
   parameter int                    NUM_REGS    = 8,
   parameter int                    OFFSET_W    = 12,
   parameter int                    WAIT_CYCLES = 2,
   parameter logic [APB_DATA_W-1:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
   input  logic           HCLK,
   input  logic           HRSTn,
   apb_reg_slave_if.slave bus
);

   localparam int IDX_W  = OFFSET_W - 2;
   localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   state_t                state_q;
   state_t                state_d;
   logic [IDX_W-1:0]      setup_idx;
   logic [RIDX_W-1:0]     setup_ridx;
   logic                  setup_err;
   logic                  setup;
   logic                  acc_go;
   logic                  done;
   logic                  cnt_zero;
   logic [RIDX_W-1:0]     ridx_q;
   logic                  wr_q;
   logic                  err_q;
   logic [APB_DATA_W-1:0] rdata_q;
   logic [APB_DATA_W-1:0] regs [NUM_REGS];

   // Upper address bits are decoded by the bridge, byte offset is irrelevant.
   logic unused_addr;
   assign unused_addr = ^{bus.PADDR[APB_DATA_W-1:OFFSET_W], bus.PADDR[1:0]};

   assign setup_idx  = bus.PADDR[OFFSET_W-1:2];
   assign setup_ridx = setup_idx[RIDX_W-1:0];
   // Range check uses the full offset so high offset bits cannot alias a valid register.
   assign setup_err  = ({{(32-IDX_W){1'b0}}, setup_idx} >= 32'(NUM_REGS))
                     | (bus.PWRITE & (setup_idx == '0));

   assign setup  = (state_q == IDLE)   & bus.PSEL & ~bus.PENABLE;
   assign acc_go = (state_q == ACCESS) & bus.PSEL &  bus.PENABLE;
   assign done   = acc_go & cnt_zero;

   apb_wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait (
      .HCLK  (HCLK),
      .HRSTn (HRSTn),
      .load  (setup),
      .dec   (acc_go),
      .zero  (cnt_zero)
   );

   always_ff @(posedge HCLK) begin
      if (!HRSTn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (setup) state_d = ACCESS;
         end
         ACCESS: begin
            // Dropping PSEL mid-access abandons the transfer without a response.
            if (!bus.PSEL || done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.PREADY  = (state_q == ACCESS) & cnt_zero;
      bus.PRDATA  = (bus.PREADY & ~wr_q) ? rdata_q : '0;
`ifdef APB_SLVERR_EN
      bus.PSLVERR = bus.PREADY & err_q;
`else
      bus.PSLVERR = 1'b0;
`endif
   end

   // Read data is captured at setup so wait states never see a moving register.
   always_ff @(posedge HCLK) begin
      if (!HRSTn) begin
         ridx_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else if (setup) begin
         ridx_q  <= setup_ridx;
         wr_q    <= bus.PWRITE;
         err_q   <= setup_err;
         rdata_q <= setup_err ? '0 :
                    (setup_idx == '0) ? ID_VALUE : regs[setup_ridx];
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRSTn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (done && wr_q && !err_q) begin
         for (int b = 0; b < APB_STRB_W; b++) begin
            if (bus.PSTRB[b]) regs[ridx_q][8*b +: 8] <= bus.PWDATA[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb/tb_apb_reg_slave.sv - directed self-checking bench for apb_reg_slave
module tb_apb_reg_slave;

`ifdef APB_SLVERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic        HCLK;
   logic        HRSTn;
   logic        tgt;
   logic        p_sel, p_en, p_write;
   logic [31:0] p_addr, p_wdata;
   logic [3:0]  p_strb;
   logic [31:0] o_rdata;
   logic        o_ready, o_slverr;

   int total = 0;
   int bad   = 0;

   logic [31:0] rd;
   logic        er;
   int          nw;

   apb_reg_slave_if bus2 ();
   apb_reg_slave_if bus0 ();

   assign bus2.PSEL    = p_sel & ~tgt;
   assign bus2.PENABLE = p_en;
   assign bus2.PWRITE  = p_write;
   assign bus2.PADDR   = p_addr;
   assign bus2.PWDATA  = p_wdata;
   assign bus2.PSTRB   = p_strb;
   assign bus0.PSEL    = p_sel & tgt;
   assign bus0.PENABLE = p_en;
   assign bus0.PWRITE  = p_write;
   assign bus0.PADDR   = p_addr;
   assign bus0.PWDATA  = p_wdata;
   assign bus0.PSTRB   = p_strb;

   assign o_rdata  = tgt ? bus0.PRDATA  : bus2.PRDATA;
   assign o_ready  = tgt ? bus0.PREADY  : bus2.PREADY;
   assign o_slverr = tgt ? bus0.PSLVERR : bus2.PSLVERR;

   apb_reg_slave #(.WAIT_CYCLES(2)) dut2 (
      .HCLK  (HCLK),
      .HRSTn (HRSTn),
      .bus   (bus2)
   );

   apb_reg_slave #(.WAIT_CYCLES(0)) dut0 (
      .HCLK  (HCLK),
      .HRSTn (HRSTn),
      .bus   (bus0)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Starts #1 after a clock edge; ends #1 after the completion edge with the bus idle.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata,
                       output logic slverr, output int waits);
      p_sel = 1'b1; p_en = 1'b0; p_write = wr;
      p_addr = addr; p_wdata = wdata; p_strb = strb;
      @(posedge HCLK); #1;
      p_en  = 1'b1;
      waits = 0;
      while (o_ready !== 1'b1 && waits < 20) begin
         @(posedge HCLK); #1;
         waits++;
      end
      if (waits >= 20) chk("pready_timeout", {31'b0, o_ready}, 32'd1);
      rdata  = o_rdata;
      slverr = o_slverr;
      @(posedge HCLK); #1;
      p_sel = 1'b0; p_en = 1'b0;
   endtask

   initial begin
      HRSTn = 1'b0; tgt = 1'b0;
      p_sel = 1'b0; p_en = 1'b0; p_write = 1'b0;
      p_addr = '0; p_wdata = '0; p_strb = '0;
      repeat (3) @(posedge HCLK);
      #1;
      chk("rst_pready",  {31'b0, o_ready},  32'd0);
      chk("rst_prdata",  o_rdata,           32'd0);
      chk("rst_pslverr", {31'b0, o_slverr}, 32'd0);
      HRSTn = 1'b1;
      @(posedge HCLK); #1;

      // Full write with two wait states, then readback.
      xfer(1'b1, 32'h4, 32'h1234_5678, 4'hF, rd, er, nw);
      chk("wr4_waits",  nw,            32'd2);
      chk("wr4_slverr", {31'b0, er},   32'd0);
      xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, er, nw);
      chk("rd4_data",   rd,            32'h1234_5678);
      chk("rd4_waits",  nw,            32'd2);

      // Partial strobes, then an all-zero strobe write.
      xfer(1'b1, 32'h4, 32'hDEAD_BEEF, 4'h3, rd, er, nw);
      xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, er, nw);
      chk("strb3_data", rd,            32'h1234_BEEF);
      xfer(1'b1, 32'h4, 32'hFFFF_FFFF, 4'h0, rd, er, nw);
      chk("strb0_waits", nw,           32'd2);
      xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, er, nw);
      chk("strb0_data", rd,            32'h1234_BEEF);

      // ID register.
      xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, nw);
      chk("id_data",    rd,            32'hA5B0_0001);
      chk("id_slverr",  {31'b0, er},   32'd0);
      xfer(1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, rd, er, nw);
      chk("idwr_slverr", {31'b0, er},  {31'b0, EXP_ERR});
      chk("idwr_waits", nw,            32'd2);
      xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, nw);
      chk("id_after_wr", rd,           32'hA5B0_0001);

      // Out of range and upper-address wrap.
      xfer(1'b0, 32'h20, 32'h0, 4'h0, rd, er, nw);
      chk("oor_data",   rd,            32'd0);
      chk("oor_slverr", {31'b0, er},   {31'b0, EXP_ERR});
      chk("oor_waits",  nw,            32'd2);
      xfer(1'b0, 32'hC000_0004, 32'h0, 4'h0, rd, er, nw);
      chk("wrap_data",  rd,            32'h1234_BEEF);

      // Reset during a wait state of a write to 0x8.
      p_sel = 1'b1; p_en = 1'b0; p_write = 1'b1;
      p_addr = 32'h8; p_wdata = 32'h55AA_55AA; p_strb = 4'hF;
      @(posedge HCLK); #1;
      p_en = 1'b1;
      chk("rstmid_wait", {31'b0, o_ready}, 32'd0);
      HRSTn = 1'b0;
      @(posedge HCLK); #1;
      chk("rstmid_pready",  {31'b0, o_ready},  32'd0);
      chk("rstmid_prdata",  o_rdata,           32'd0);
      chk("rstmid_pslverr", {31'b0, o_slverr}, 32'd0);
      HRSTn = 1'b1; p_sel = 1'b0; p_en = 1'b0;
      @(posedge HCLK); #1;
      xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, er, nw);
      chk("rstmid_reg8", rd,           32'd0);
      xfer(1'b0, 32'h4, 32'h0, 4'h0, rd, er, nw);
      chk("rstmid_reg4", rd,           32'd0);

      // Zero-wait slave: back-to-back write then read.
      tgt = 1'b1;
      xfer(1'b1, 32'hC, 32'hCAFE_F00D, 4'hF, rd, er, nw);
      chk("zw_wr_waits", nw,           32'd0);
      xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, er, nw);
      chk("zw_rd_waits", nw,           32'd0);
      chk("zw_rd_data",  rd,           32'hCAFE_F00D);

      // Abort: PSEL drops in ACCESS before PENABLE, nothing is written.
      p_sel = 1'b1; p_en = 1'b0; p_write = 1'b1;
      p_addr = 32'h10; p_wdata = 32'h1111_1111; p_strb = 4'hF;
      @(posedge HCLK); #1;
      chk("abort_access", {31'b0, o_ready}, 32'd1);
      p_sel = 1'b0;
      @(posedge HCLK); #1;
      chk("abort_idle",   {31'b0, o_ready}, 32'd0);
      xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, nw);
      chk("abort_nowrite", rd,         32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
